fetch_unit: RTL and testbench

- Instruction fetch stage for the RISC-V core. Owns the PC register and fetches from instruction memory over a req/ack handshake.
- Presents the fetched word to decode; its bits [31:7] feed the immediate generator.
- Computes the next PC from the immediate generator's extended immediate (ImmExt) and the control unit's PCSrc.
- Holds the current instruction while the downstream stage stalls.

---
 rtl/fetch_unit.sv | 84 ++++++++
 tb/tb_fetch_unit.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// RISC-V instruction fetch stage: owns the PC, fetches over a req/ack handshake,
// holds the fetched word while decode stalls and computes the next PC.
module fetch_unit #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_ack,
  input  logic [WIDTH-1:0] imem_rdata,
  output logic [WIDTH-1:0] instr,
  output logic             instr_valid,
  input  logic             stall,
  input  logic             PCSrc,
  input  logic [WIDTH-1:0] ImmExt,
  output logic [WIDTH-1:0] PC,
  output logic [WIDTH-1:0] PCPlus4,
  output logic [WIDTH-1:0] PCTarget,
  output logic             misaligned
);

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_VALID = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] r_instr;
  logic             r_valid;
  logic             r_mis;
  logic [WIDTH-1:0] w_next;

  assign PCPlus4  = r_pc + WIDTH'(4);
  assign PCTarget = r_pc + ImmExt;
  assign w_next   = PCSrc ? PCTarget : PCPlus4;

  // Request is gated by rst so an in-flight fetch is dropped the same cycle.
  assign imem_req    = (r_state == S_REQ) && !rst;
  assign imem_addr   = r_pc;
  assign instr       = r_instr;
  assign instr_valid = r_valid;
  assign PC          = r_pc;
  assign misaligned  = r_mis;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_REQ;
      r_pc    <= RESET_PC;
      r_instr <= '0;
      r_valid <= 1'b0;
      r_mis   <= 1'b0;
    end else begin
      unique case (r_state)
        S_REQ: begin
          if (imem_ack) begin
            r_instr <= imem_rdata;
            r_valid <= 1'b1;
            r_state <= S_VALID;
          end
        end
        S_VALID: begin
          // PCSrc/ImmExt only matter on the consume edge.
          if (!stall) begin
            r_valid <= 1'b0;
            if (w_next[1:0] == 2'b00) begin
              r_pc    <= w_next;
              r_state <= S_REQ;
            end else begin
              r_mis   <= 1'b1;
              r_state <= S_HALT;
            end
          end
        end
        S_HALT: ;
        default: r_state <= S_HALT;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed cycle table, wrap check on a second instance,
// then randomized traffic against a transaction-level reference model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, ack, stall, pcsrc;
  logic [31:0] rdata, imm;
  logic        req, valid, mis;
  logic [31:0] addr, instr, pc, plus4, target;

  fetch_unit #(.WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .imem_req(req), .imem_addr(addr), .imem_ack(ack),
    .imem_rdata(rdata), .instr(instr), .instr_valid(valid), .stall(stall),
    .PCSrc(pcsrc), .ImmExt(imm), .PC(pc), .PCPlus4(plus4), .PCTarget(target),
    .misaligned(mis)
  );

  logic        rst_w;
  logic        w_req, w_valid, w_mis;
  logic [31:0] w_addr, w_instr, w_pc, w_plus4, w_target;
  logic        ack_w    = 1'b1;
  logic        stall_w  = 1'b0;
  logic        pcsrc_w  = 1'b0;
  logic [31:0] rdata_w  = 32'h0000_0013;
  logic [31:0] imm_w    = 32'h0;

  fetch_unit #(.WIDTH(32), .RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .rst(rst_w), .imem_req(w_req), .imem_addr(w_addr), .imem_ack(ack_w),
    .imem_rdata(rdata_w), .instr(w_instr), .instr_valid(w_valid), .stall(stall_w),
    .PCSrc(pcsrc_w), .ImmExt(imm_w), .PC(w_pc), .PCPlus4(w_plus4), .PCTarget(w_target),
    .misaligned(w_mis)
  );

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  typedef struct {
    logic        rst, ack, stall, pcsrc;
    logic [31:0] rdata, imm;
    logic        e_req, e_valid, e_mis;
    logic [31:0] e_instr, e_pc;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic r, input logic a, input logic [31:0] d,
                              input logic s, input logic ps, input logic [31:0] im,
                              input logic er, input logic ev, input logic [31:0] ei,
                              input logic [31:0] ep, input logic em);
    vec_t v;
    v.rst = r; v.ack = a; v.rdata = d; v.stall = s; v.pcsrc = ps; v.imm = im;
    v.e_req = er; v.e_valid = ev; v.e_instr = ei; v.e_pc = ep; v.e_mis = em;
    return v;
  endfunction

  localparam logic [31:0] N   = 32'h0000_0013;
  localparam logic [31:0] BAD = 32'hDEAD_BEEF;
  localparam logic [31:0] I1  = 32'h0010_0093;
  localparam logic [31:0] I2  = 32'h0020_0113;
  localparam logic [31:0] I3  = 32'h0030_0193;
  localparam logic [31:0] I4  = 32'h0040_0213;
  localparam logic [31:0] I5  = 32'h0050_0293;

  // reference model state (transaction view: what instruction is held, where, halted?)
  logic [31:0] m_pc, m_instr;
  logic        m_holding, m_halted, m_mis;

  task automatic check_outputs(input string tag, input logic e_req, input logic e_valid,
                               input logic [31:0] e_instr, input logic [31:0] e_pc,
                               input logic e_mis);
    chk({tag, ".req"},    {31'd0, req},   {31'd0, e_req});
    chk({tag, ".valid"},  {31'd0, valid}, {31'd0, e_valid});
    chk({tag, ".instr"},  instr,          e_instr);
    chk({tag, ".pc"},     pc,             e_pc);
    chk({tag, ".mis"},    {31'd0, mis},   {31'd0, e_mis});
    chk({tag, ".plus4"},  plus4,          e_pc + 32'd4);
    chk({tag, ".target"}, target,         e_pc + imm);
    if (e_req) chk({tag, ".addr"}, addr, e_pc);
  endtask

  initial begin
    rst = 1'b1; rst_w = 1'b1; ack = 1'b0; stall = 1'b0; pcsrc = 1'b0;
    rdata = '0; imm = '0;
    repeat (2) @(posedge clk);

    // wrap: FFFF_FFFC + 4 -> 0
    @(negedge clk); rst_w = 1'b0; #1;
    chk("wrap.req0",   {31'd0, w_req},   32'd1);
    chk("wrap.addr0",  w_addr,           32'hFFFF_FFFC);
    chk("wrap.valid0", {31'd0, w_valid}, 32'd0);
    @(negedge clk); #1;
    chk("wrap.valid1", {31'd0, w_valid}, 32'd1);
    chk("wrap.plus4",  w_plus4,          32'h0);
    chk("wrap.req1",   {31'd0, w_req},   32'd0);
    @(negedge clk); #1;
    chk("wrap.pc",     w_pc,             32'h0);
    chk("wrap.addr2",  w_addr,           32'h0);
    chk("wrap.mis",    {31'd0, w_mis},   32'd0);

    // directed cycle table: inputs for the cycle, outputs expected before its edge
    vq.push_back(mk(1,1,BAD,0,0,32'h0,        0,0,32'h0,32'h00,0)); // 0 reset, ack ignored
    vq.push_back(mk(0,1,N,  0,0,32'h0,        1,0,32'h0,32'h00,0)); // 1 zero-wait fetch @0
    vq.push_back(mk(0,0,0,  0,0,32'h0,        0,1,N,    32'h00,0)); // 2 consume
    vq.push_back(mk(0,0,0,  0,0,32'h0,        1,0,N,    32'h04,0)); // 3 wait 1
    vq.push_back(mk(0,0,0,  0,0,32'h0,        1,0,N,    32'h04,0)); // 4 wait 2
    vq.push_back(mk(0,0,0,  0,0,32'h0,        1,0,N,    32'h04,0)); // 5 wait 3
    vq.push_back(mk(0,1,I1, 0,0,32'h0,        1,0,N,    32'h04,0)); // 6 ack
    vq.push_back(mk(0,0,0,  0,0,32'h0,        0,1,I1,   32'h04,0)); // 7
    vq.push_back(mk(0,1,N,  0,0,32'h0,        1,0,I1,   32'h08,0)); // 8
    vq.push_back(mk(0,0,0,  0,0,32'h0,        0,1,N,    32'h08,0)); // 9
    vq.push_back(mk(0,1,I2, 0,0,32'h0,        1,0,N,    32'h0C,0)); // 10
    vq.push_back(mk(0,0,0,  0,0,32'h0,        0,1,I2,   32'h0C,0)); // 11
    vq.push_back(mk(0,1,I3, 0,0,32'h0,        1,0,I2,   32'h10,0)); // 12
    vq.push_back(mk(0,0,0,  1,1,32'h100,      0,1,I3,   32'h10,0)); // 13 stall
    vq.push_back(mk(0,1,BAD,1,0,32'h40,       0,1,I3,   32'h10,0)); // 14 stall, stray ack
    vq.push_back(mk(0,0,0,  1,1,32'hFFFF_FFF0,0,1,I3,   32'h10,0)); // 15
    vq.push_back(mk(0,0,0,  1,0,32'h2,        0,1,I3,   32'h10,0)); // 16
    vq.push_back(mk(0,0,0,  1,1,32'h6,        0,1,I3,   32'h10,0)); // 17
    vq.push_back(mk(0,0,0,  0,1,32'hFFFF_FFF8,0,1,I3,   32'h10,0)); // 18 branch back to 8
    vq.push_back(mk(0,1,I4, 0,0,32'h0,        1,0,I3,   32'h08,0)); // 19
    vq.push_back(mk(0,0,0,  0,1,32'h2,        0,1,I4,   32'h08,0)); // 20 misaligned target
    vq.push_back(mk(0,1,BAD,0,0,32'h0,        0,0,I4,   32'h08,1)); // 21 halted
    vq.push_back(mk(0,1,BAD,0,1,32'h0,        0,0,I4,   32'h08,1)); // 22
    vq.push_back(mk(1,0,0,  0,0,32'h0,        0,0,I4,   32'h08,1)); // 23 reset
    vq.push_back(mk(0,0,0,  0,0,32'h0,        1,0,32'h0,32'h00,0)); // 24 restart fetch
    vq.push_back(mk(0,0,0,  0,0,32'h0,        1,0,32'h0,32'h00,0)); // 25 waiting
    vq.push_back(mk(1,1,BAD,0,0,32'h0,        0,0,32'h0,32'h00,0)); // 26 rst + ack
    vq.push_back(mk(0,0,0,  0,0,32'h0,        1,0,32'h0,32'h00,0)); // 27 ack was dropped
    vq.push_back(mk(0,1,I5, 0,0,32'h0,        1,0,32'h0,32'h00,0)); // 28
    vq.push_back(mk(0,0,0,  0,0,32'h0,        0,1,I5,   32'h00,0)); // 29

    foreach (vq[i]) begin
      @(negedge clk);
      rst = vq[i].rst; ack = vq[i].ack; rdata = vq[i].rdata;
      stall = vq[i].stall; pcsrc = vq[i].pcsrc; imm = vq[i].imm;
      #1;
      check_outputs($sformatf("vec%0d", i), vq[i].e_req, vq[i].e_valid,
                    vq[i].e_instr, vq[i].e_pc, vq[i].e_mis);
    end

    // randomized phase
    @(negedge clk); rst = 1'b1; ack = 1'b0; stall = 1'b0; pcsrc = 1'b0; imm = '0;
    @(negedge clk);
    m_pc = 32'h0; m_instr = 32'h0; m_holding = 1'b0; m_halted = 1'b0; m_mis = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic        e_req;
      logic [31:0] nxt;
      if (cyc != 0) @(negedge clk);
      rst   = m_halted ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 199) == 0);
      ack   = ($urandom_range(0, 2) != 0);
      rdata = $urandom;
      stall = ($urandom_range(0, 9) < 3);
      pcsrc = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 39) == 0) imm = 32'($urandom_range(1, 3));
      else if ($urandom_range(0, 1) == 1) imm = 32'($urandom_range(0, 63)) * 4;
      else imm = -(32'($urandom_range(0, 63)) * 4);
      #1;
      e_req = !rst && !m_holding && !m_halted;
      check_outputs($sformatf("rnd%0d", cyc), e_req, m_holding, m_instr, m_pc, m_mis);

      if (rst) begin
        m_pc = 32'h0; m_instr = 32'h0; m_holding = 1'b0; m_halted = 1'b0; m_mis = 1'b0;
      end else if (e_req && ack) begin
        m_instr = rdata; m_holding = 1'b1;
      end else if (m_holding && !stall) begin
        nxt = pcsrc ? m_pc + imm : m_pc + 32'd4;
        m_holding = 1'b0;
        if (nxt % 4 == 0) m_pc = nxt;
        else begin m_mis = 1'b1; m_halted = 1'b1; end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
